// File: rtl/rv_iommu_msi_if_extract_if.sv
// Request/response bundle for the MSI interrupt-file number extractor.
// Both sides use valid/ready: a transfer happens on the rising edge where valid and ready are both high.
interface rv_iommu_msi_if_extract_if #(
  parameter int ADDR_W = 52
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] gpaddr_i;
  logic [ADDR_W-1:0] mask_i;
  logic [ADDR_W-1:0] pattern_i;
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [ADDR_W-1:0] imsic_num_o;
  logic              is_msi_o;

  modport slave (
    input  req_valid_i, gpaddr_i, mask_i, pattern_i, resp_ready_i,
    output req_ready_o, resp_valid_o, imsic_num_o, is_msi_o
  );

  modport master (
    output req_valid_i, gpaddr_i, mask_i, pattern_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, imsic_num_o, is_msi_o
  );
endinterface

// File: rtl/rv_iommu_msi_if_extract.sv
// Multi-cycle bit-extract of GPA bits selected by msi_addr_mask into a dense IF number,
// plus an msi_addr_pattern match flag computed at accept time.
module rv_iommu_msi_if_extract #(
  parameter int ADDR_W         = 52,
  parameter int BITS_PER_CYCLE = 13
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  rv_iommu_msi_if_extract_if.slave    bus,
  output logic [1:0]                  state_dbg
);

  localparam int NSTEPS = ADDR_W / BITS_PER_CYCLE;
  localparam int STEP_W = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam int IDX_W  = $clog2(ADDR_W + 1);
  localparam int K_W    = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;

  if (ADDR_W % BITS_PER_CYCLE != 0) begin : g_param_err
    $error("ADDR_W must be a multiple of BITS_PER_CYCLE");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXTRACT = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e            state_q;
  logic [STEP_W-1:0] step_q;
  logic [IDX_W-1:0]  idx_q;
  logic [ADDR_W-1:0] gpa_q;
  logic [ADDR_W-1:0] mask_q;
  logic [ADDR_W-1:0] num_q;
  logic              msi_q;
  logic              req_ready_q;
  logic              resp_valid_q;

  logic [ADDR_W-1:0] num_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic [K_W-1:0]    k;
  logic              last_step;
  logic              msi_in;

  // One slice of the scan: walk the mask bits of this step in ascending order and
  // pack each selected GPA bit into the next free position of the IF number.
  always_comb begin
    num_nxt = num_q;
    idx_nxt = idx_q;
    k       = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      k = K_W'(int'(step_q) * BITS_PER_CYCLE + j);
      if (mask_q[k]) begin
        if (idx_nxt < IDX_W'(ADDR_W)) begin
          num_nxt[idx_nxt[K_W-1:0]] = gpa_q[k];
        end
        idx_nxt = idx_nxt + IDX_W'(1);
      end
    end
  end

  assign last_step = (step_q == STEP_W'(NSTEPS - 1));
  assign msi_in    = (((bus.gpaddr_i ^ bus.pattern_i) & ~bus.mask_i) == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      step_q       <= '0;
      idx_q        <= '0;
      gpa_q        <= '0;
      mask_q       <= '0;
      num_q        <= '0;
      msi_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else if (flush_i) begin
      // Result of a flushed request is dropped; outputs keep their last value.
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid_i && req_ready_q) begin
            gpa_q       <= bus.gpaddr_i & bus.mask_i;
            mask_q      <= bus.mask_i;
            msi_q       <= msi_in;
            num_q       <= '0;
            step_q      <= '0;
            idx_q       <= '0;
            req_ready_q <= 1'b0;
            state_q     <= EXTRACT;
          end
        end
        EXTRACT: begin
          num_q <= num_nxt;
          idx_q <= idx_nxt;
          if (last_step) begin
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        DONE: begin
          if (resp_valid_q && bus.resp_ready_i) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready_o  = req_ready_q;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.imsic_num_o  = num_q;
  assign bus.is_msi_o     = msi_q;
  assign state_dbg        = state_q;

endmodule
